alu_cmd_dispatch: RTL and testbench
===================================

Name: alu_cmd_dispatch

Overview:
- Command front-end directly upstream of the IEEE754 ALU top (add/sub/mul/div).
- Accepts tagged operand/opcode commands over a valid/ready interface and buffers them in a small FIFO.
- Issues one command at a time to the ALU with a single-cycle trig pulse, then waits for vld.
- Returns each result with its tag over a valid/ready response port; a watchdog converts a hung operation into an error response.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, >=2)
- TAG_W, 4, command tag width
- TIMEOUT_CYC, 255, max cycles in WAIT before error (>=1, fits 16 bits)

Ports:
- sys_clk  in  1  clock
- sys_rst  in  1  reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  FIFO not full
- cmd_data1  in  32  operand 1 (IEEE754 single)
- cmd_data2  in  32  operand 2
- cmd_opcode  in  2  00 add, 01 sub, 10 mul, 11 div
- cmd_tag  in  TAG_W  command tag
- alu_data1  out  32  operand 1 to ALU
- alu_data2  out  32  operand 2 to ALU
- alu_opcode  out  2  opcode to ALU
- alu_trig  out  1  one-cycle start pulse
- alu_result  in  32  ALU data_out
- alu_vld  in  1  ALU result valid (one-cycle pulse)
- alu_work  in  1  ALU busy
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_data  out  32  result, or 32'h7FC00000 on timeout
- rsp_tag  out  TAG_W  tag of the completed command
- rsp_err  out  1  timeout flag
- fifo_level  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Interface: one clock (sys_clk); reset is synchronous and active-high (sys_rst). Every register updates only on the rising edge of sys_clk.
- Reset values: all outputs 0, FIFO empty, FSM in IDLE, watchdog cleared. cmd_ready returns to 1 in the first cycle after reset deasserts.
- Enqueue: cmd_valid && cmd_ready at edge E pushes {data1, data2, opcode, tag}.
- cmd_ready = !full. There is no full-bypass: a pop and a push in the same cycle while full is impossible because cmd_ready=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE -> ISSUE when the FIFO is non-empty and alu_work==0. On this edge the FIFO head is popped into the alu_* registers and alu_trig is set.
- ISSUE: alu_trig=1 for exactly this cycle. Go to WAIT unconditionally. alu_vld is ignored in ISSUE.
- WAIT: the watchdog increments each cycle.
  - On alu_vld: capture alu_result into rsp_data, set rsp_err=0, go to RESP.
  - Else, when watchdog==TIMEOUT_CYC: rsp_data=32'h7FC00000, rsp_err=1, go to RESP.
  - If alu_vld arrives in the same cycle the watchdog hits its limit, the valid result wins.
- RESP: rsp_valid=1. rsp_data, rsp_tag and rsp_err are held stable until rsp_ready. On handshake, clear rsp_valid and return to IDLE.
- alu_data1, alu_data2 and alu_opcode are held from ISSUE through RESP.
- Minimum latency: with an empty FIFO, accept at edge E0 -> alu_trig high in the cycle after E1 -> rsp_valid high one cycle after the alu_vld cycle.
- alu_vld seen in IDLE or RESP (stray or late) is ignored.
- Ordering: strictly in order, one command outstanding at a time.
- Reset mid-operation: FIFO is flushed and the in-flight command is dropped without a response. Because IDLE waits for alu_work==0, nothing is issued until a still-busy ALU finishes.

Optional Feature:
- Macro ALU_DISPATCH_STATS_EN.
- When defined: adds outputs stat_done (16 bit) and stat_timeout (16 bit).
  - stat_done counts completed responses; stat_timeout counts rsp_err responses.
  - Both saturate at 16'hFFFF and are cleared by sys_rst.
- When undefined: these ports and their logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg: opcode constants (OP_ADD, OP_SUB, OP_MUL, OP_DIV), FP_QNAN = 32'h7FC00000, dispatch FSM state enum.
- Sub-module alu_cmd_fifo: synchronous FIFO with width 66+TAG_W, DEPTH entries, ports push/pop/full/empty/level.

Test Plan:
- Add path: push 3FC00000 + 40100000, op 00, tag 3; ALU model responds 40700000 after 5 cycles -> one alu_trig pulse; rsp_data=40700000, rsp_tag=3, rsp_err=0.
- Back-to-back fill: push 5 commands with rsp_ready=1 and ALU stalled -> cmd_ready drops after the 4th accept (DEPTH=4); tags 0..4 return in order once the ALU is released.
- Backpressure: mul 40000000 x 40400000 with rsp_ready=0 for 10 cycles -> rsp_valid, rsp_data=40C00000 and rsp_tag held stable; the next command is not issued until the response handshake.
- Timeout: ALU model never asserts alu_vld, TIMEOUT_CYC=20 -> rsp_err=1 and rsp_data=7FC00000 exactly 20 cycles after entering WAIT. The coincident case (alu_vld on the limit cycle) -> rsp_err=0.
- Reset mid-WAIT with alu_work held high for 3 further cycles -> no response emitted; after reset, alu_trig is withheld until alu_work==0; the stray alu_vld is ignored.
- Stats (with ALU_DISPATCH_STATS_EN): 3 normal ops + 1 timeout -> stat_done=4, stat_timeout=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command dispatcher: opcodes, the quiet-NaN
// error payload and the dispatch FSM state encoding.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } disp_state_e;

endpackage

// File: rtl/alu_cmd_dispatch_if.sv
// Bundle of the command, ALU and response handshakes around the dispatcher.
// The slave modport is the dispatcher itself; master is its environment.
interface alu_cmd_dispatch_if #(
    parameter int TAG_W = 4
);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_data1;
    logic [31:0]      cmd_data2;
    logic [1:0]       cmd_opcode;
    logic [TAG_W-1:0] cmd_tag;

    logic [31:0]      alu_data1;
    logic [31:0]      alu_data2;
    logic [1:0]       alu_opcode;
    logic             alu_trig;
    logic [31:0]      alu_result;
    logic             alu_vld;
    logic             alu_work;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_data1, cmd_data2, cmd_opcode, cmd_tag,
        input  cmd_ready,
        input  alu_data1, alu_data2, alu_opcode, alu_trig,
        output alu_result, alu_vld, alu_work,
        input  rsp_valid, rsp_data, rsp_tag, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_data1, cmd_data2, cmd_opcode, cmd_tag,
        output cmd_ready,
        output alu_data1, alu_data2, alu_opcode, alu_trig,
        input  alu_result, alu_vld, alu_work,
        output rsp_valid, rsp_data, rsp_tag, rsp_err,
        input  rsp_ready
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; storage is not reset, only
// the pointers and level are.
module alu_cmd_fifo #(
    parameter int WIDTH = 70,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      level_d = level_q + LW'(1);
        else if (do_pop && !do_push) level_d = level_q - LW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/alu_cmd_dispatch.sv
// Buffers tagged ALU commands, issues them one at a time and returns tagged
// results, turning a hung operation into a NaN error. ALU_DISPATCH_STATS_EN adds counters.
module alu_cmd_dispatch
    import alu_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    alu_cmd_dispatch_if.slave      bus,
    output logic [$clog2(DEPTH):0] fifo_level
`ifdef ALU_DISPATCH_STATS_EN
    ,
    output logic [15:0]            stat_done,
    output logic [15:0]            stat_timeout
`endif
);

    localparam int          FW         = 66 + TAG_W;
    localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT_CYC);

    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [FW-1:0]    fifo_rdata;

    disp_state_e      state_q;
    logic [31:0]      alu_data1_q, alu_data2_q, rsp_data_q;
    logic [1:0]       alu_opcode_q;
    logic [TAG_W-1:0] tag_q;
    logic             alu_trig_q, rsp_valid_q, rsp_err_q;
    logic [15:0]      wdog_q;

    // Ready is gated by reset so nothing is accepted while the FIFO is flushed.
    assign bus.cmd_ready = !fifo_full && !sys_rst;
    assign fifo_push     = bus.cmd_valid && bus.cmd_ready;
    assign fifo_pop      = (state_q == ST_IDLE) && !fifo_empty && !bus.alu_work;

    alu_cmd_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i ({bus.cmd_data1, bus.cmd_data2, bus.cmd_opcode, bus.cmd_tag}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign bus.alu_data1  = alu_data1_q;
    assign bus.alu_data2  = alu_data2_q;
    assign bus.alu_opcode = alu_opcode_q;
    assign bus.alu_trig   = alu_trig_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_tag    = tag_q;
    assign bus.rsp_err    = rsp_err_q;

    // The watchdog holds the number of cycles spent in WAIT, current one included.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= ST_IDLE;
            alu_data1_q  <= '0;
            alu_data2_q  <= '0;
            alu_opcode_q <= '0;
            tag_q        <= '0;
            alu_trig_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            wdog_q       <= '0;
        end else begin
            alu_trig_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        {alu_data1_q, alu_data2_q, alu_opcode_q, tag_q} <= fifo_rdata;
                        alu_trig_q <= 1'b1;
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wdog_q  <= 16'd1;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.alu_vld) begin
                        rsp_data_q  <= bus.alu_result;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else if (wdog_q == WDOG_LIMIT) begin
                        rsp_data_q  <= FP_QNAN;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        wdog_q <= wdog_q + 16'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_DISPATCH_STATS_EN
    // Counters advance on the response handshake and stick at all-ones.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            stat_done    <= '0;
            stat_timeout <= '0;
        end else if (rsp_valid_q && bus.rsp_ready) begin
            if (stat_done != 16'hFFFF) stat_done <= stat_done + 16'd1;
            if (rsp_err_q && stat_timeout != 16'hFFFF) stat_timeout <= stat_timeout + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_dispatch.sv
// Directed bench for alu_cmd_dispatch: a vector table for single commands plus
// hand-written fill, backpressure and reset sequences against a small ALU model.
module tb_alu_cmd_dispatch;
    import alu_pkg::*;

    localparam int TAG_W   = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 20;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [1:0]  op;
        logic [3:0]  tag;
        int          lat;
        bit          hang;
        logic [31:0] expData;
        bit          expErr;
        int          expCycles;
    } vec_t;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic sysClk = 1'b0;
    logic sysRst = 1'b1;
    always #5 sysClk = ~sysClk;

    alu_cmd_dispatch_if #(.TAG_W(TAG_W)) bus ();
    logic [$clog2(DEPTH):0] fifoLevel;
`ifdef ALU_DISPATCH_STATS_EN
    logic [15:0] statDone, statTimeout;
`endif

    alu_cmd_dispatch #(
        .DEPTH       (DEPTH),
        .TAG_W       (TAG_W),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .sys_clk    (sysClk),
        .sys_rst    (sysRst),
        .bus        (bus.slave),
        .fifo_level (fifoLevel)
`ifdef ALU_DISPATCH_STATS_EN
        ,
        .stat_done    (statDone),
        .stat_timeout (statTimeout)
`endif
    );

    logic        modelBusy    = 1'b0;
    logic        modelWork    = 1'b0;
    logic        modelVld     = 1'b0;
    logic [31:0] modelResult  = 32'h0;
    logic [31:0] modelA       = 32'h0;
    logic [31:0] modelB       = 32'h0;
    logic [1:0]  modelOp      = 2'b00;
    int          modelCnt     = 0;
    int          modelLatency = 1;
    logic        modelHang    = 1'b0;
    logic        modelAbort   = 1'b0;
    logic        stallWork    = 1'b0;
    logic        strayVld     = 1'b0;

    assign bus.alu_work   = modelWork || stallWork;
    assign bus.alu_vld    = modelVld || strayVld;
    assign bus.alu_result = strayVld ? 32'hDEAD_BEEF : modelResult;

    int   trigCount = 0;
    rsp_t rspLog[$];
    int   checksRun = 0;
    int   checksPassed = 0;
    vec_t vecs[7];

    // Stand-in for the floating-point ALU: known IEEE754 cases, otherwise a
    // distinctive operand mix.
    function automatic logic [31:0] fakeAlu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
        logic [65:0] key;
        key = {op, a, b};
        case (key)
            {OP_ADD, 32'h3FC0_0000, 32'h4010_0000}: return 32'h4070_0000;
            {OP_SUB, 32'h4010_0000, 32'h3FC0_0000}: return 32'h3F40_0000;
            {OP_MUL, 32'h4000_0000, 32'h4040_0000}: return 32'h40C0_0000;
            {OP_DIV, 32'h40C0_0000, 32'h4000_0000}: return 32'h4040_0000;
            {OP_ADD, 32'h3F80_0000, 32'h3F80_0000}: return 32'h4000_0000;
            default: return a ^ b ^ {30'd0, op};
        endcase
    endfunction

    // ALU model acts 2 time units after each rising edge, well clear of sampling.
    always @(posedge sysClk) begin
        #2;
        modelVld = 1'b0;
        if (modelAbort) begin
            modelBusy = 1'b0;
            modelWork = 1'b0;
        end else if (modelBusy) begin
            if (!modelHang) begin
                modelCnt = modelCnt - 1;
                if (modelCnt <= 0) begin
                    modelVld    = 1'b1;
                    modelResult = fakeAlu(modelA, modelB, modelOp);
                    modelBusy   = 1'b0;
                    modelWork   = 1'b0;
                end
            end
        end else if (bus.alu_trig) begin
            modelBusy = 1'b1;
            modelWork = 1'b1;
            modelCnt  = modelLatency;
            modelA    = bus.alu_data1;
            modelB    = bus.alu_data2;
            modelOp   = bus.alu_opcode;
        end
    end

    always @(posedge sysClk) begin
        if (bus.alu_trig) trigCount <= trigCount + 1;
        if (bus.rsp_valid && bus.rsp_ready) rspLog.push_back('{bus.rsp_tag, bus.rsp_data, bus.rsp_err});
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running, required to finish");
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checksRun++;
        if (actual === expected) checksPassed++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic pushCmd(input logic [31:0] d1, input logic [31:0] d2, input logic [1:0] op,
                           input logic [3:0] tag);
        @(negedge sysClk);
        bus.cmd_data1  = d1;
        bus.cmd_data2  = d2;
        bus.cmd_opcode = op;
        bus.cmd_tag    = tag;
        bus.cmd_valid  = 1'b1;
        @(negedge sysClk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic waitResponses(input int target, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (rspLog.size() >= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge sysClk);
        end
        checkOutput(name, 32'(ok), 32'd1);
    endtask

    // Single command from an idle dispatcher with an empty FIFO.
    task automatic applyStimulus(input vec_t v);
        int trigBefore;
        int cycles;
        bit seen;
        modelLatency = v.lat;
        modelHang    = v.hang;
        @(negedge sysClk);
        checkOutput("cmd_ready idle", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_data1  = v.d1;
        bus.cmd_data2  = v.d2;
        bus.cmd_opcode = v.op;
        bus.cmd_tag    = v.tag;
        bus.cmd_valid  = 1'b1;
        trigBefore     = trigCount;
        @(negedge sysClk);
        bus.cmd_valid = 1'b0;
        @(negedge sysClk);
        checkOutput("alu_trig latency", 32'(bus.alu_trig), 32'd1);
        checkOutput("alu_data1", bus.alu_data1, v.d1);
        checkOutput("alu_data2", bus.alu_data2, v.d2);
        checkOutput("alu_opcode", 32'(bus.alu_opcode), 32'(v.op));
        seen   = 1'b0;
        cycles = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge sysClk);
            if (bus.rsp_valid) begin
                seen   = 1'b1;
                cycles = i;
                break;
            end
        end
        checkOutput("rsp_valid seen", 32'(seen), 32'd1);
        checkOutput("rsp latency", 32'(cycles), 32'(v.expCycles));
        checkOutput("rsp_data", bus.rsp_data, v.expData);
        checkOutput("rsp_tag", 32'(bus.rsp_tag), 32'(v.tag));
        checkOutput("rsp_err", 32'(bus.rsp_err), 32'(v.expErr));
        checkOutput("alu_data1 held", bus.alu_data1, v.d1);
        checkOutput("trig pulse count", 32'(trigCount - trigBefore), 32'd1);
        @(negedge sysClk);
        checkOutput("rsp_valid after handshake", 32'(bus.rsp_valid), 32'd0);
        if (v.hang) begin
            modelAbort = 1'b1;
            @(negedge sysClk);
            modelAbort = 1'b0;
        end
    endtask

    initial begin
        int          base;
        int          trigBefore;
        bit          stable;
        logic [31:0] holdData;
        logic [3:0]  holdTag;

        vecs[0] = '{32'h3FC0_0000, 32'h4010_0000, OP_ADD, 4'd3, 5, 1'b0, 32'h4070_0000, 1'b0, 6};
        vecs[1] = '{32'h4010_0000, 32'h3FC0_0000, OP_SUB, 4'd1, 3, 1'b0, 32'h3F40_0000, 1'b0, 4};
        vecs[2] = '{32'h4000_0000, 32'h4040_0000, OP_MUL, 4'd2, 1, 1'b0, 32'h40C0_0000, 1'b0, 2};
        vecs[3] = '{32'h40C0_0000, 32'h4000_0000, OP_DIV, 4'd4, 8, 1'b0, 32'h4040_0000, 1'b0, 9};
        vecs[4] = '{32'h3F80_0000, 32'h4000_0000, OP_DIV, 4'd7, 1, 1'b1, 32'h7FC0_0000, 1'b1, TIMEOUT + 1};
        vecs[5] = '{32'h4000_0000, 32'h4040_0000, OP_MUL, 4'd10, TIMEOUT, 1'b0, 32'h40C0_0000, 1'b0, TIMEOUT + 1};
        vecs[6] = '{32'h3FC0_0000, 32'h4010_0000, OP_ADD, 4'd11, TIMEOUT + 1, 1'b0, 32'h7FC0_0000, 1'b1, TIMEOUT + 1};

        bus.cmd_valid  = 1'b0;
        bus.cmd_data1  = '0;
        bus.cmd_data2  = '0;
        bus.cmd_opcode = '0;
        bus.cmd_tag    = '0;
        bus.rsp_ready  = 1'b1;

        repeat (3) @(negedge sysClk);
        checkOutput("reset cmd_ready", 32'(bus.cmd_ready), 32'd0);
        checkOutput("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset alu_trig", 32'(bus.alu_trig), 32'd0);
        checkOutput("reset rsp_data", bus.rsp_data, 32'd0);
        checkOutput("reset fifo_level", 32'(fifoLevel), 32'd0);
        sysRst = 1'b0;
        #1;
        checkOutput("cmd_ready after reset", 32'(bus.cmd_ready), 32'd1);

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

        // Fill the FIFO while the ALU reports busy, then drain in order.
        $display("[TB] fill sequence");
        modelLatency = 1;
        modelHang    = 1'b0;
        stallWork    = 1'b1;
        base         = rspLog.size();
        for (int i = 0; i < 4; i++) begin
            @(negedge sysClk);
            bus.cmd_data1  = 32'h1111_0000 + 32'(i);
            bus.cmd_data2  = 32'(32'h0101_0101 * (i + 1));
            bus.cmd_opcode = 2'(i);
            bus.cmd_tag    = 4'(i);
            bus.cmd_valid  = 1'b1;
        end
        @(negedge sysClk);
        checkOutput("fill cmd_ready full", 32'(bus.cmd_ready), 32'd0);
        checkOutput("fill level", 32'(fifoLevel), 32'd4);
        bus.cmd_data1  = 32'h1111_0004;
        bus.cmd_data2  = 32'(32'h0101_0101 * 5);
        bus.cmd_opcode = 2'd0;
        bus.cmd_tag    = 4'd4;
        stallWork      = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.cmd_ready) break;
            @(negedge sysClk);
        end
        @(negedge sysClk);
        bus.cmd_valid = 1'b0;
        waitResponses(base + 5, "fill responses arrive");
        for (int i = 0; i < 5; i++) begin
            if (rspLog.size() > base + i) begin
                checkOutput("fill tag order", 32'(rspLog[base + i].tag), 32'(i));
                checkOutput("fill data", rspLog[base + i].data,
                            fakeAlu(32'h1111_0000 + 32'(i), 32'(32'h0101_0101 * (i + 1)), 2'(i % 4)));
            end
        end

        // Response held under backpressure; the queued command waits.
        $display("[TB] backpressure sequence");
        repeat (2) @(negedge sysClk);
        bus.rsp_ready = 1'b0;
        modelLatency  = 2;
        base          = rspLog.size();
        pushCmd(32'h4000_0000, 32'h4040_0000, OP_MUL, 4'd5);
        pushCmd(32'h3F80_0000, 32'h3F80_0000, OP_ADD, 4'd6);
        for (int i = 0; i < 50; i++) begin
            if (bus.rsp_valid) break;
            @(negedge sysClk);
        end
        checkOutput("bp rsp_valid", 32'(bus.rsp_valid), 32'd1);
        checkOutput("bp rsp_data", bus.rsp_data, 32'h40C0_0000);
        checkOutput("bp rsp_tag", 32'(bus.rsp_tag), 32'd5);
        holdData   = bus.rsp_data;
        holdTag    = bus.rsp_tag;
        trigBefore = trigCount;
        stable     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge sysClk);
            if (!bus.rsp_valid || bus.rsp_data !== holdData || bus.rsp_tag !== holdTag) stable = 1'b0;
        end
        checkOutput("bp response stable", 32'(stable), 32'd1);
        checkOutput("bp no issue while held", 32'(trigCount - trigBefore), 32'd0);
        checkOutput("bp queued level", 32'(fifoLevel), 32'd1);
        bus.rsp_ready = 1'b1;
        waitResponses(base + 2, "bp responses arrive");
        if (rspLog.size() >= base + 2) begin
            checkOutput("bp second tag", 32'(rspLog[base + 1].tag), 32'd6);
            checkOutput("bp second data", rspLog[base + 1].data, 32'h4000_0000);
        end

        // Reset in WAIT while the ALU stays busy, followed by a late stray result.
        $display("[TB] reset sequence");
        repeat (2) @(negedge sysClk);
        modelHang    = 1'b1;
        modelLatency = 1;
        pushCmd(32'h3FC0_0000, 32'h4010_0000, OP_ADD, 4'd8);
        pushCmd(32'h4000_0000, 32'h4040_0000, OP_MUL, 4'd12);
        repeat (5) @(negedge sysClk);
        checkOutput("queued before reset", 32'(fifoLevel), 32'd1);
        base       = rspLog.size();
        sysRst     = 1'b1;
        stallWork  = 1'b1;
        modelAbort = 1'b1;
        modelHang  = 1'b0;
        modelLatency = 2;
        @(negedge sysClk);
        modelAbort = 1'b0;
        checkOutput("in reset cmd_ready", 32'(bus.cmd_ready), 32'd0);
        checkOutput("in reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset flushes fifo", 32'(fifoLevel), 32'd0);
        checkOutput("reset clears alu_data1", bus.alu_data1, 32'd0);
        sysRst = 1'b0;
        trigBefore = trigCount;
        pushCmd(32'h3F80_0000, 32'h3F80_0000, OP_ADD, 4'd9);
        repeat (3) @(negedge sysClk);
        checkOutput("no trig while alu_work", 32'(trigCount - trigBefore), 32'd0);
        checkOutput("no rsp after reset", 32'(bus.rsp_valid), 32'd0);
        checkOutput("post-reset level", 32'(fifoLevel), 32'd1);
        stallWork = 1'b0;
        strayVld  = 1'b1;
        @(negedge sysClk);
        strayVld = 1'b0;
        waitResponses(base + 1, "post-reset response arrives");
        if (rspLog.size() >= base + 1) begin
            checkOutput("post-reset tag", 32'(rspLog[base].tag), 32'd9);
            checkOutput("post-reset data", rspLog[base].data, 32'h4000_0000);
            checkOutput("post-reset err", 32'(rspLog[base].err), 32'd0);
        end
        repeat (5) @(negedge sysClk);
        checkOutput("dropped command silent", 32'(rspLog.size()), 32'(base + 1));

`ifdef ALU_DISPATCH_STATS_EN
        $display("[TB] stats sequence");
        sysRst = 1'b1;
        @(negedge sysClk);
        sysRst = 1'b0;
        checkOutput("stat_done reset", 32'(statDone), 32'd0);
        applyStimulus(vecs[0]);
        applyStimulus(vecs[1]);
        applyStimulus(vecs[2]);
        applyStimulus(vecs[4]);
        checkOutput("stat_done", 32'(statDone), 32'd4);
        checkOutput("stat_timeout", 32'(statTimeout), 32'd1);
`endif

        $display("%0d/%0d checks passed", checksPassed, checksRun);
        $finish;
    end

endmodule
